video_mode_sequencer: RTL and testbench
=======================================

Name: video_mode_sequencer

Overview:
Controls the test-pattern video core (timing generator, LFSR and cosine datapath). It accepts pal/scandouble mode-change requests from the OSD/HPS side. Each change is applied only at a frame boundary: the sequencer waits for VBlank, holds the core in reset, switches the configuration, releases the core, and waits a set number of frames for timing to settle before acknowledging. It also performs the power-on release of the core.

Parameters:
HOLD_CYCLES, 16, cycles core_reset stays high after each config switch (>=1)
SETTLE_FRAMES, 2, VSync rising edges required after release before ack (>=1)
TIMEOUT_CYCLES, 2000000, max cycles waiting for a VBlank/VSync edge before forcing progress
CNT_W, 21, width of the shared cycle counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock; same clock that drives the video core
reset_n  in  1  asynchronous, active-low reset
cfg_req  in  1  request strobe; sampled every cycle
cfg_pal  in  1  requested pal, valid when cfg_req=1
cfg_scandouble  in  1  requested scandouble, valid when cfg_req=1
cfg_ack  out  1  one-cycle pulse: the request has been applied and is stable
cfg_busy  out  1  high while any sequence is in progress
timeout  out  1  sticky: last sequence hit a timeout
vblank  in  1  VBlank from the video core
vsync  in  1  VSync from the video core
core_reset  out  1  active-high reset to the video core
core_pal  out  1  applied pal
core_scandouble  out  1  applied scandouble

Behaviour:
- All outputs are registered. vblank and vsync are in the clk domain, so no synchroniser is used. One registered copy of each gives a rising-edge detect.
- Reset values: state=HOLD, core_reset=1, core_pal=0, core_scandouble=0, cfg_ack=0, cfg_busy=1, timeout=0, pending=0, counter=0, edge registers=0.
- Pending slot, one deep:
  - A cycle with cfg_req=1 loads pend_pal/pend_sd and sets pending=1. A newer request overwrites an older one (newest wins).
  - This applies in every state, including while busy.
- IDLE (busy=0):
  - If pending=1, clear pending and latch target = pend.
  - If target equals the current core_pal/core_scandouble, go to ACK (no-op; ack is 2 cycles after the req cycle).
  - Otherwise clear timeout, reset counter, go to WAIT_BLANK.
- WAIT_BLANK:
  - On a vblank rising edge, go to HOLD.
  - If the counter reaches TIMEOUT_CYCLES-1, set timeout=1 and go to HOLD.
- HOLD:
  - core_reset=1. On entry, core_pal/core_scandouble <= target (power-on: defaults of 0).
  - After HOLD_CYCLES cycles in HOLD, drive core_reset=0, clear the counter and frame count, and go to SETTLE.
- SETTLE:
  - Count vsync rising edges. The per-frame counter restarts on each edge.
  - On count == SETTLE_FRAMES, go to ACK.
  - If the per-frame counter reaches TIMEOUT_CYCLES-1, set timeout=1 and go to ACK.
  - vsync edges seen while in HOLD are ignored.
- ACK: cfg_ack=1 for exactly one cycle, then IDLE. cfg_busy=0 is first seen in the IDLE cycle.
- After power-on reset, the sequencer runs HOLD then SETTLE then ACK with defaults, so a single cfg_ack pulse appears with no request.
- Simultaneous events:
  - A req arriving in the ACK cycle is kept in pending and serviced from IDLE on the next cycle.
  - A vblank edge in the same cycle as the timeout terminal count goes to HOLD with timeout=0 (the edge wins).
- reset_n asserted mid-sequence: immediately return to reset values. core_reset goes high asynchronously and any pending request is lost.
- Counters saturate; they do not wrap.

Decomposition:
- Shared package video_pkg holds:
  - the state enum (IDLE, WAIT_BLANK, HOLD, SETTLE, ACK);
  - the mode struct {pal, scandouble};
  - NTSC/PAL line-count constants (262/312, 524/624), used by the bench to predict frame timing.
- One sub-module is natural: edge_det, a registered rising-edge detector with async active-low reset, instantiated twice (vblank, vsync).

Test Plan:
- Power-on: release reset_n with the core model running NTSC, no scandouble, SETTLE_FRAMES=2 -> core_reset high for 16 cycles, core_pal=0, then exactly one cfg_ack pulse after the 2nd vsync rise; busy drops the cycle after.
- Mode change: cfg_req with pal=1, sd=0 mid-frame at NTSC line 100 -> core_reset rises the cycle after the next vblank rise (line 240), stays high 16 cycles, core_pal=1; ack after 2 PAL frames (2×312 lines); timeout=0.
- No-op: cfg_req with pal=0, sd=0 while the core is already in that mode and idle -> cfg_ack exactly 2 cycles later, core_reset never asserted.
- Overwrite: req pal=1 during WAIT_BLANK, then req sd=1, pal=0 during SETTLE -> first sequence acks with pal=1; the second sequence then runs and ends with core_pal=0, core_scandouble=1; exactly two acks.
- Timeout: vblank held at 0, TIMEOUT_CYCLES=1000 -> at cycle 999 of WAIT_BLANK, timeout=1 and HOLD is entered; the sticky flag stays set until the next non-no-op request leaves IDLE.
- Async reset mid-HOLD: drop reset_n for 1 cycle at HOLD cycle 5 -> core_reset=1 and core_pal=0 immediately; pending is cleared; the power-on sequence repeats.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the test-pattern video mode sequencer.
// State encodings are plain constants so older tooling can consume them unchanged.
package video_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_WAIT_BLANK = 3'd1;
    localparam state_t ST_HOLD       = 3'd2;
    localparam state_t ST_SETTLE     = 3'd3;
    localparam state_t ST_ACK        = 3'd4;

    typedef struct packed {
        logic pal;
        logic scandouble;
    } mode_t;

    // Total lines per frame; scandouble doubles the line count at half the line time.
    localparam int NTSC_LINES    = 32'd262;
    localparam int PAL_LINES     = 32'd312;
    localparam int NTSC_LINES_SD = 32'd524;
    localparam int PAL_LINES_SD  = 32'd624;

    function automatic logic same_mode(input mode_t a, input mode_t b);
        return (a.pal == b.pal) && (a.scandouble == b.scandouble);
    endfunction

endpackage

// File: rtl/video_mode_sequencer_edge_det.sv
// Registered rising-edge detector; the input is already in the clk domain.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_r;

    // One-cycle delayed copy of the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= 1'b0;
        end else begin
            d_r <= d;
        end
    end

    assign rise = d & ~d_r;

endmodule

// File: rtl/video_mode_sequencer.sv
// Applies pal/scandouble changes to the video core at frame boundaries: wait for
// VBlank, hold the core in reset while switching, then wait for timing to settle.
module video_mode_sequencer
    import video_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int SETTLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cfg_req,
    input  logic cfg_pal,
    input  logic cfg_scandouble,
    output logic cfg_ack,
    output logic cfg_busy,
    output logic timeout,
    input  logic vblank,
    input  logic vsync,
    output logic core_reset,
    output logic core_pal,
    output logic core_scandouble
);

    localparam int FR_W = $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FR_W-1:0]  FR_DONE   = FR_W'(SETTLE_FRAMES);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [FR_W-1:0]  frames_r;
    mode_t            pend_r;
    logic             pending_r;
    mode_t            target_r;
    mode_t            core_mode_r;
    logic             core_reset_r;
    logic             ack_r;
    logic             busy_r;
    logic             timeout_r;

    mode_t            req_mode_s;
    logic             vblank_rise_s;
    logic             vsync_rise_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [FR_W-1:0]  frames_inc_s;

    edge_det u_vblank_edge (.clk(clk), .rst_n(reset_n), .d(vblank), .rise(vblank_rise_s));
    edge_det u_vsync_edge  (.clk(clk), .rst_n(reset_n), .d(vsync),  .rise(vsync_rise_s));

    assign req_mode_s   = '{pal: cfg_pal, scandouble: cfg_scandouble};
    assign cnt_inc_s    = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    assign frames_inc_s = (frames_r == {FR_W{1'b1}}) ? frames_r : frames_r + FR_W'(1);

    // One-deep request slot; a request in the same cycle IDLE consumes the slot re-arms it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= 1'b0;
            pend_r    <= '0;
        end else if (cfg_req) begin
            pending_r <= 1'b1;
            pend_r    <= req_mode_s;
        end else if (state_r == ST_IDLE) begin
            pending_r <= 1'b0;
        end
    end

    // Sequencing FSM; reset lands in HOLD so power-on performs a full release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_HOLD;
            cnt_r        <= '0;
            frames_r     <= '0;
            target_r     <= '0;
            core_mode_r  <= '0;
            core_reset_r <= 1'b1;
            ack_r        <= 1'b0;
            busy_r       <= 1'b1;
            timeout_r    <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pending_r) begin
                        target_r <= pend_r;
                        busy_r   <= 1'b1;
                        if (same_mode(pend_r, core_mode_r)) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                        end else begin
                            timeout_r <= 1'b0;
                            cnt_r     <= '0;
                            state_r   <= ST_WAIT_BLANK;
                        end
                    end
                end
                ST_WAIT_BLANK: begin
                    // A real VBlank edge beats a coincident terminal count
                    if (vblank_rise_s || (cnt_r == TO_LAST)) begin
                        if (!vblank_rise_s) begin
                            timeout_r <= 1'b1;
                        end
                        core_reset_r <= 1'b1;
                        core_mode_r  <= target_r;
                        cnt_r        <= '0;
                        state_r      <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        core_reset_r <= 1'b0;
                        cnt_r        <= '0;
                        frames_r     <= '0;
                        state_r      <= ST_SETTLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_SETTLE: begin
                    if (vsync_rise_s) begin
                        cnt_r    <= '0;
                        frames_r <= frames_inc_s;
                        if (frames_inc_s == FR_DONE) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                        end
                    end else if (cnt_r == TO_LAST) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_ACK;
                        ack_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_ACK: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    core_reset_r <= 1'b1;
                    cnt_r        <= '0;
                    busy_r       <= 1'b1;
                    state_r      <= ST_HOLD;
                end
            endcase
        end
    end

    assign cfg_ack         = ack_r;
    assign cfg_busy        = busy_r;
    assign timeout         = timeout_r;
    assign core_reset      = core_reset_r;
    assign core_pal        = core_mode_r.pal;
    assign core_scandouble = core_mode_r.scandouble;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Scoreboard bench: stimulus queues the expected ack, a monitor checks every ack,
// core_reset pulse and VBlank alignment against a simple line-counting core model.
module tb_video_mode_sequencer;
    import video_pkg::*;

    localparam int HOLD = 16;
    localparam int TO   = 1000;
    // Two cycles per line: first vsync at line 244/292, then one full frame, plus one detect cycle.
    localparam int LAT_NTSC = 2 * 244 + 2 * NTSC_LINES + 1;  // 1013
    localparam int LAT_PAL  = 2 * 292 + 2 * PAL_LINES + 1;   // 1209

    logic clk;
    logic reset_n;
    logic cfg_req, cfg_pal, cfg_scandouble;
    logic cfg_ack, cfg_busy, timeout;
    logic vblank, vsync;
    logic core_reset, core_pal, core_scandouble;
    logic kill;

    video_mode_sequencer #(
        .HOLD_CYCLES(16), .SETTLE_FRAMES(2), .TIMEOUT_CYCLES(TO), .CNT_W(21)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_req(cfg_req), .cfg_pal(cfg_pal), .cfg_scandouble(cfg_scandouble),
        .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .timeout(timeout),
        .vblank(vblank), .vsync(vsync),
        .core_reset(core_reset), .core_pal(core_pal), .core_scandouble(core_scandouble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core timing model
    int m_line = 0, m_pix = 0;
    int cpl_s, lpf_s, act_s, vs_s;
    always_comb begin
        cpl_s = core_scandouble ? 1 : 2;
        if (core_pal) lpf_s = core_scandouble ? PAL_LINES_SD : PAL_LINES;
        else          lpf_s = core_scandouble ? NTSC_LINES_SD : NTSC_LINES;
        act_s = (core_pal ? 288 : 240) * (core_scandouble ? 2 : 1);
        vs_s  = act_s + (core_scandouble ? 8 : 4);
    end
    always @(posedge clk) begin
        if (core_reset) begin
            m_line <= 0;
            m_pix  <= 0;
        end else if (m_pix == cpl_s - 1) begin
            m_pix  <= 0;
            m_line <= (m_line == lpf_s - 1) ? 0 : m_line + 1;
        end else begin
            m_pix <= m_pix + 1;
        end
    end
    assign vblank = !kill && (m_line >= act_s);
    assign vsync  = !kill && (m_line >= vs_s) && (m_line < vs_s + 6);

    typedef struct {
        bit pal;
        bit sd;
        bit to;
        bit from_req;
        int lat;
    } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0;
    int cyc = 0, fall_cyc = 0, rise_cyc = 0, hold_start = 0, vb_rise_cyc = 0, req_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input bit pal, input bit sd, input bit to, input bit from_req, input int lat);
        exp_t e;
        e.pal = pal; e.sd = sd; e.to = to; e.from_req = from_req; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic send(input bit pal, input bit sd);
        cfg_req = 1'b1; cfg_pal = pal; cfg_scandouble = sd; req_cyc = cyc;
        @(negedge clk);
        cfg_req = 1'b0; cfg_pal = 1'b0; cfg_scandouble = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !cfg_busy) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_cr(input logic lvl, input string name);
        int ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (core_reset === lvl) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        exp_t e;
        logic prev_cr, prev_vb, chk_after;
        prev_cr = 1'b1; prev_vb = 1'b0; chk_after = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!reset_n) begin
                hold_start = cyc;
                chk_after  = 1'b0;
            end else begin
                if (vblank && !prev_vb) vb_rise_cyc = cyc;
                if (chk_after) begin
                    chk("ack_one_cycle", int'(cfg_ack), 0);
                    chk("busy_after_ack", int'(cfg_busy), 0);
                    chk_after = 1'b0;
                end
                if (core_reset && !prev_cr) begin
                    rise_cyc = cyc;
                    hold_start = cyc;
                    chk("reset_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        chk("hold_pal", int'(core_pal), int'(sb[0].pal));
                        chk("hold_sd", int'(core_scandouble), int'(sb[0].sd));
                    end
                end
                if (!core_reset && prev_cr) begin
                    fall_cyc = cyc;
                    chk("hold_len", cyc - hold_start, HOLD);
                end
                if (cfg_ack) begin
                    chk_after = 1'b1;
                    chk("busy_at_ack", int'(cfg_busy), 1);
                    chk("ack_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("ack_pal", int'(core_pal), int'(e.pal));
                        chk("ack_sd", int'(core_scandouble), int'(e.sd));
                        chk("ack_timeout", int'(timeout), int'(e.to));
                        chk("ack_latency", e.from_req ? cyc - req_cyc : cyc - fall_cyc, e.lat);
                    end
                end
            end
            prev_cr = core_reset;
            prev_vb = vblank;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int ok;
        cfg_req = 1'b0; cfg_pal = 1'b0; cfg_scandouble = 1'b0; kill = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_core_pal", int'(core_pal), 0);
        chk("rst_core_sd", int'(core_scandouble), 0);
        chk("rst_ack", int'(cfg_ack), 0);
        chk("rst_busy", int'(cfg_busy), 1);
        chk("rst_timeout", int'(timeout), 0);

        // Power-on release with defaults
        expect_ack(1'b0, 1'b0, 1'b0, 1'b0, LAT_NTSC);
        reset_n = 1'b1;
        wait_idle("poweron_idle");

        // No-op request
        repeat (5) @(negedge clk);
        expect_ack(1'b0, 1'b0, 1'b0, 1'b1, 2);
        send(1'b0, 1'b0);
        wait_idle("noop_idle");

        // Mode change issued mid-frame at NTSC line 100
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_line == 100) begin
                ok = 1;
                break;
            end
        end
        chk("line100_seen", ok, 1);
        expect_ack(1'b1, 1'b0, 1'b0, 1'b0, LAT_PAL);
        send(1'b1, 1'b0);
        wait_cr(1'b1, "mode_reset_rise");
        chk("blank_to_hold", rise_cyc - vb_rise_cyc, 1);
        wait_idle("mode_idle");
        chk("mode_pal", int'(core_pal), 1);
        chk("mode_timeout", int'(timeout), 0);

        // Async reset in the middle of HOLD, with a request pending
        expect_ack(1'b1, 1'b1, 1'b0, 1'b0, LAT_PAL);
        send(1'b1, 1'b1);
        wait_cr(1'b1, "hold_reset_rise");
        repeat (4) @(negedge clk);
        send(1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_core_reset", int'(core_reset), 1);
        chk("async_core_pal", int'(core_pal), 0);
        chk("async_core_sd", int'(core_scandouble), 0);
        chk("async_busy", int'(cfg_busy), 1);
        sb.delete();
        expect_ack(1'b0, 1'b0, 1'b0, 1'b0, LAT_NTSC);
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle("reset_idle");
        repeat (60) @(negedge clk);
        chk("pending_lost_busy", int'(cfg_busy), 0);
        chk("pending_lost_sd", int'(core_scandouble), 0);

        // Overwrite: second sequence queued during SETTLE, newest request wins
        expect_ack(1'b1, 1'b0, 1'b0, 1'b0, LAT_PAL);
        send(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("wb_busy", int'(cfg_busy), 1);
        chk("wb_no_reset", int'(core_reset), 0);
        wait_cr(1'b1, "ow_rise");
        wait_cr(1'b0, "ow_fall");
        repeat (100) @(negedge clk);
        expect_ack(1'b0, 1'b1, 1'b0, 1'b0, LAT_NTSC);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        wait_idle("overwrite_idle");
        chk("ow_pal", int'(core_pal), 0);
        chk("ow_sd", int'(core_scandouble), 1);

        // Timeout: blanking and sync suppressed
        kill = 1'b1;
        repeat (3) @(negedge clk);
        expect_ack(1'b1, 1'b1, 1'b1, 1'b0, TO);
        send(1'b1, 1'b1);
        repeat (1000) @(negedge clk);
        chk("to_not_yet", int'(timeout), 0);
        chk("to_not_yet_reset", int'(core_reset), 0);
        @(negedge clk);
        chk("to_set", int'(timeout), 1);
        chk("to_hold_reset", int'(core_reset), 1);
        wait_idle("to_idle");
        repeat (10) @(negedge clk);
        chk("to_sticky", int'(timeout), 1);
        expect_ack(1'b1, 1'b1, 1'b1, 1'b1, 2);
        send(1'b1, 1'b1);
        wait_idle("noop2_idle");
        chk("to_sticky_noop", int'(timeout), 1);
        kill = 1'b0;
        repeat (3) @(negedge clk);
        expect_ack(1'b0, 1'b0, 1'b0, 1'b0, LAT_NTSC);
        send(1'b0, 1'b0);
        chk("to_kept_in_idle", int'(timeout), 1);
        @(negedge clk);
        chk("to_cleared", int'(timeout), 0);
        wait_idle("final_idle");
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
